// File: rtl/ifetch_dispatch_if.sv
// Program-memory read bus and execution-unit dispatch bus shared by the fetch
// stage (master) and its memory/execution-unit neighbours (slave).
interface ifetch_dispatch_if #(
  parameter int AW = 8
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_data;
  logic          mem_ready;
  logic [31:0]   ir;
  logic [1:0]    sel_eu;
  logic          cs;
  logic          ready1;

  modport master (
    output mem_addr, mem_rd, ir, sel_eu, cs,
    input  mem_data, mem_ready, ready1
  );

  modport slave (
    input  mem_addr, mem_rd, ir, sel_eu, cs,
    output mem_data, mem_ready, ready1
  );
endinterface

// File: rtl/ifetch_dispatch.sv
// Instruction fetch/dispatch stage: assembles 32-bit instructions from two
// 16-bit memory reads, dispatches ALU classes and handles JMP/HALT locally.
module ifetch_dispatch #(
  parameter int AW          = 8,
  parameter int RESET_PC    = 0,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  ifetch_dispatch_if.master   bus,
  output logic [AW-2:0]       pc,
  output logic                halted,
  output logic                err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH_HI  = 3'd1;
  localparam logic [2:0] FETCH_LO  = 3'd2;
  localparam logic [2:0] DECODE    = 3'd3;
  localparam logic [2:0] DISPATCH  = 3'd4;
  localparam logic [2:0] WAIT_BUSY = 3'd5;
  localparam logic [2:0] WAIT_DONE = 3'd6;
  localparam logic [2:0] HALT      = 3'd7;

  localparam int            CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(ACK_TIMEOUT);
  localparam logic [AW-2:0] PC_RESET = (AW-1)'(RESET_PC);

  logic [2:0]    state;
  logic [31:0]   ir_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  // Memory and dispatch strobes are pure decodes of the state, so reset
  // forces them low without extra registers.
  assign bus.mem_rd   = (state == FETCH_HI) || (state == FETCH_LO);
  assign bus.mem_addr = bus.mem_rd ? {pc, state == FETCH_LO} : '0;
  assign bus.cs       = (state == DISPATCH);
  assign bus.ir       = ir_q;
  assign bus.sel_eu   = sel_q;
  assign halted       = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= PC_RESET;
      ir_q  <= '0;
      sel_q <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH_HI;
        FETCH_HI: if (bus.mem_ready) begin
          ir_q[31:16] <= bus.mem_data;
          state       <= FETCH_LO;
        end
        FETCH_LO: if (bus.mem_ready) begin
          ir_q[15:0] <= bus.mem_data;
          state      <= DECODE;
        end
        DECODE: begin
          case (ir_q[31:30])
            2'b00, 2'b01: begin
              sel_q <= ir_q[31:30];
              state <= DISPATCH;
            end
            2'b10: begin
              pc    <= ir_q[AW-2:0];
              state <= FETCH_HI;
            end
            default: state <= HALT;
          endcase
        end
        DISPATCH: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        // The execution unit must drop ready1 before a high level means done.
        WAIT_BUSY: begin
          if (!bus.ready1) begin
            state <= WAIT_DONE;
          end else if (cnt_inc == CNT_MAX) begin
            err   <= 1'b1;
            state <= HALT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_DONE: if (bus.ready1) begin
          pc    <= pc + 1'b1;
          state <= FETCH_HI;
        end
        HALT: if (start) begin
          pc    <= PC_RESET;
          err   <= 1'b0;
          state <= FETCH_HI;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_dispatch.sv
// Self-checking bench for ifetch_dispatch: cycle table, corner sequences and
// randomized programs against an instruction-level reference model.
module tb_ifetch_dispatch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] pc;
  logic       halted;
  logic       err;
  logic [15:0] mem [256];

  int errors = 0;
  int checks = 0;

  ifetch_dispatch_if #(.AW(8)) bus ();

  ifetch_dispatch #(.AW(8), .RESET_PC(0), .ACK_TIMEOUT(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus.master),
    .pc     (pc),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = mem[bus.mem_addr];

  typedef struct {
    logic        st, mr, r1;
    logic        rd;
    logic [7:0]  addr;
    logic        cs;
    logic [1:0]  sel;
    logic [31:0] ir;
    logic [6:0]  pcv;
    logic        h;
  } vec_t;

  typedef struct {
    logic [6:0]  pcv;
    logic [31:0] ir;
    logic [1:0]  sel;
  } disp_t;

  function automatic vec_t mk(input logic st, mr, r1, rd, input logic [7:0] addr,
                              input logic cs, input logic [1:0] sel,
                              input logic [31:0] ir, input logic [6:0] pcv, input logic h);
    vec_t v;
    v.st = st; v.mr = mr; v.r1 = r1; v.rd = rd; v.addr = addr; v.cs = cs;
    v.sel = sel; v.ir = ir; v.pcv = pcv; v.h = h;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic mr, input logic r1);
    start         = st;
    bus.mem_ready = mr;
    bus.ready1    = r1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    start         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ready1    = 1'b1;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runUntilCs(input string name, input int bound);
    int n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      n++;
    end while (!bus.cs && n < bound);
    checkOutput({name, ".cs_seen"}, {31'd0, bus.cs}, 32'd1);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic loadDirected();
    clearMem();
    mem[0]  = 16'h0008; mem[1]  = 16'h0005;
    mem[2]  = 16'h4001; mem[3]  = 16'hC000;
    mem[4]  = 16'h8000; mem[5]  = 16'h0005;
    mem[10] = 16'hC000; mem[11] = 16'h0000;
  endtask

  vec_t  vecs [27];
  disp_t expq [$];
  logic  sched [$];

  initial begin
    bus.mem_ready = 1'b0;
    bus.ready1    = 1'b1;
    loadDirected();

    vecs[0]  = mk(1,1,1, 1,8'd0, 0,2'd0, 32'h00000000, 7'd0, 0);
    vecs[1]  = mk(0,1,1, 1,8'd1, 0,2'd0, 32'h00080000, 7'd0, 0);
    vecs[2]  = mk(0,1,1, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[3]  = mk(0,1,1, 0,8'd0, 1,2'd0, 32'h00080005, 7'd0, 0);
    vecs[4]  = mk(0,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[5]  = mk(0,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[6]  = mk(1,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[7]  = mk(0,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[8]  = mk(0,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[9]  = mk(0,1,0, 0,8'd0, 0,2'd0, 32'h00080005, 7'd0, 0);
    vecs[10] = mk(0,1,1, 1,8'd2, 0,2'd0, 32'h00080005, 7'd1, 0);
    vecs[11] = mk(0,1,1, 1,8'd3, 0,2'd0, 32'h40010005, 7'd1, 0);
    vecs[12] = mk(0,1,1, 0,8'd0, 0,2'd0, 32'h4001C000, 7'd1, 0);
    vecs[13] = mk(0,1,1, 0,8'd0, 1,2'd1, 32'h4001C000, 7'd1, 0);
    vecs[14] = mk(0,1,1, 0,8'd0, 0,2'd1, 32'h4001C000, 7'd1, 0);
    vecs[15] = mk(0,1,1, 0,8'd0, 0,2'd1, 32'h4001C000, 7'd1, 0);
    vecs[16] = mk(0,1,0, 0,8'd0, 0,2'd1, 32'h4001C000, 7'd1, 0);
    vecs[17] = mk(0,1,1, 1,8'd4, 0,2'd1, 32'h4001C000, 7'd2, 0);
    vecs[18] = mk(0,1,1, 1,8'd5, 0,2'd1, 32'h8000C000, 7'd2, 0);
    vecs[19] = mk(1,1,1, 0,8'd0, 0,2'd1, 32'h80000005, 7'd2, 0);
    vecs[20] = mk(0,1,1, 1,8'd10, 0,2'd1, 32'h80000005, 7'd5, 0);
    vecs[21] = mk(0,1,1, 1,8'd11, 0,2'd1, 32'hC0000005, 7'd5, 0);
    vecs[22] = mk(0,1,1, 0,8'd0, 0,2'd1, 32'hC0000000, 7'd5, 0);
    vecs[23] = mk(0,1,1, 0,8'd0, 0,2'd1, 32'hC0000000, 7'd5, 1);
    vecs[24] = mk(0,1,1, 0,8'd0, 0,2'd1, 32'hC0000000, 7'd5, 1);
    vecs[25] = mk(1,1,1, 1,8'd0, 0,2'd1, 32'hC0000000, 7'd0, 0);
    vecs[26] = mk(0,1,1, 1,8'd1, 0,2'd1, 32'h00080000, 7'd0, 0);

    // Reset state
    applyReset();
    checkOutput("reset.mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    checkOutput("reset.cs", {31'd0, bus.cs}, 32'd0);
    checkOutput("reset.ir", bus.ir, 32'd0);
    checkOutput("reset.pc", {25'd0, pc}, 32'd0);
    checkOutput("reset.halted", {31'd0, halted}, 32'd0);

    // Cycle table: ALU imm, ALU reg, JMP, HALT and restart
    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i].st, vecs[i].mr, vecs[i].r1);
      checkOutput($sformatf("row%0d.mem_rd", i), {31'd0, bus.mem_rd}, {31'd0, vecs[i].rd});
      checkOutput($sformatf("row%0d.mem_addr", i), {24'd0, bus.mem_addr}, {24'd0, vecs[i].addr});
      checkOutput($sformatf("row%0d.cs", i), {31'd0, bus.cs}, {31'd0, vecs[i].cs});
      checkOutput($sformatf("row%0d.sel_eu", i), {30'd0, bus.sel_eu}, {30'd0, vecs[i].sel});
      checkOutput($sformatf("row%0d.ir", i), bus.ir, vecs[i].ir);
      checkOutput($sformatf("row%0d.pc", i), {25'd0, pc}, {25'd0, vecs[i].pcv});
      checkOutput($sformatf("row%0d.halted", i), {31'd0, halted}, {31'd0, vecs[i].h});
      checkOutput($sformatf("row%0d.err", i), {31'd0, err}, 32'd0);
    end

    // Memory stalls of 3 cycles in each fetch half delay cs to cycle 10
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("stall_hi.mem_rd", {31'd0, bus.mem_rd}, 32'd1);
      checkOutput("stall_hi.mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("stall_lo.mem_rd", {31'd0, bus.mem_rd}, 32'd1);
      checkOutput("stall_lo.mem_addr", {24'd0, bus.mem_addr}, 32'd1);
      checkOutput("stall_lo.cs", {31'd0, bus.cs}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stall.ir", bus.ir, 32'h00080005);
    checkOutput("stall.cs_early", {31'd0, bus.cs}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("stall.cs_cycle10", {31'd0, bus.cs}, 32'd1);

    // ready1 never drops: timeout after 4 WAIT_BUSY cycles
    repeat (4) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("timeout.halted_early", {31'd0, halted}, 32'd0);
      checkOutput("timeout.err_early", {31'd0, err}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("timeout.halted", {31'd0, halted}, 32'd1);
    checkOutput("timeout.err", {31'd0, err}, 32'd1);
    checkOutput("timeout.mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("restart.halted", {31'd0, halted}, 32'd0);
    checkOutput("restart.err", {31'd0, err}, 32'd0);
    checkOutput("restart.mem_addr", {24'd0, bus.mem_addr}, 32'd0);

    // Asynchronous reset while waiting for the second instruction to finish
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    runUntilCs("rst1", 10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    runUntilCs("rst2", 10);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("rst.pc_before", {25'd0, pc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst.pc", {25'd0, pc}, 32'd0);
    checkOutput("rst.ir", bus.ir, 32'd0);
    checkOutput("rst.sel_eu", {30'd0, bus.sel_eu}, 32'd0);
    checkOutput("rst.mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("rst.no_fetch", {31'd0, bus.mem_rd}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst.start_fetch", {31'd0, bus.mem_rd}, 32'd1);

    // pc wrap from all-ones back to zero
    clearMem();
    mem[0]   = 16'h8000; mem[1]   = 16'h007F;
    mem[254] = 16'h0000; mem[255] = 16'h0001;
    applyReset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    runUntilCs("wrap", 20);
    checkOutput("wrap.pc127", {25'd0, pc}, 32'd127);
    checkOutput("wrap.ir", bus.ir, 32'h00000001);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("wrap.pc0", {25'd0, pc}, 32'd0);
    checkOutput("wrap.mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    checkOutput("wrap.mem_rd", {31'd0, bus.mem_rd}, 32'd1);

    // Randomized programs checked against an instruction-level model
    for (int prog = 0; prog < 8; prog++) begin
      logic [31:0] word;
      logic [31:0] savedIr;
      logic        irPending;
      int          mpc;
      int          cyc;
      clearMem();
      for (int i = 0; i < 16; i++) begin
        int cls;
        cls  = (i == 15) ? 3 : $urandom_range(0, 2);
        word = $urandom;
        word[31:30] = cls[1:0];
        if (cls == 2) word[6:0] = 7'($urandom_range(i + 1, 15));
        mem[2*i]   = word[31:16];
        mem[2*i+1] = word[15:0];
      end
      expq.delete();
      mpc = 0;
      while (1) begin
        word = {mem[2*mpc], mem[2*mpc+1]};
        if (word[31:30] == 2'b11) break;
        if (word[31:30] == 2'b10) begin
          mpc = int'(word[6:0]);
        end else begin
          expq.push_back('{pcv: 7'(mpc), ir: word, sel: word[31:30]});
          mpc = (mpc + 1) % 128;
        end
      end

      applyReset();
      sched.delete();
      irPending = 1'b0;
      savedIr   = '0;
      applyStimulus(1'b1, 1'b1, 1'b1);
      cyc = 0;
      while (!halted && cyc < 3000) begin
        logic r1;
        r1 = (sched.size() != 0) ? sched.pop_front() : 1'b1;
        applyStimulus(1'b0, ($urandom_range(0, 2) != 0), r1);
        cyc++;
        if (irPending && sched.size() == 0) begin
          checkOutput($sformatf("rand%0d.ir_stable", prog), bus.ir, savedIr);
          irPending = 1'b0;
        end
        if (bus.cs) begin
          if (expq.size() == 0) begin
            checkOutput($sformatf("rand%0d.extra_cs", prog), {31'd0, bus.cs}, 32'd0);
          end else begin
            disp_t e;
            e = expq.pop_front();
            checkOutput($sformatf("rand%0d.ir", prog), bus.ir, e.ir);
            checkOutput($sformatf("rand%0d.sel_eu", prog), {30'd0, bus.sel_eu}, {30'd0, e.sel});
            checkOutput($sformatf("rand%0d.pc", prog), {25'd0, pc}, {25'd0, e.pcv});
          end
          savedIr   = bus.ir;
          irPending = 1'b1;
          sched.push_back(1'b1);
          repeat ($urandom_range(0, 2)) sched.push_back(1'b1);
          repeat ($urandom_range(1, 4)) sched.push_back(1'b0);
        end
      end
      checkOutput($sformatf("rand%0d.halted", prog), {31'd0, halted}, 32'd1);
      checkOutput($sformatf("rand%0d.err", prog), {31'd0, err}, 32'd0);
      checkOutput($sformatf("rand%0d.left", prog), expq.size(), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifetch_dispatch.md
Name: ifetch_dispatch

Overview:
- Instruction fetch/dispatch stage that sits directly upstream of the execution unit.
- Reads 32-bit instructions from a 16-bit program memory as two words, then latches them onto ir.
- Decodes the instruction class. ALU classes go to the execution unit with sel_eu and a one-cycle cs pulse.
- Jump and halt are handled locally. After each dispatch the block waits for the execution unit's ready1 busy/done handshake before fetching again.

Parameters:
AW, 8, program-memory word-address width; PC is AW-1 bits (instruction index)
RESET_PC, 0, PC value after reset and on restart
ACK_TIMEOUT, 4, max cycles to wait for ready1 to fall after cs pulse

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution from IDLE; restart from HALT
mem_addr  output  AW  program-memory word address
mem_rd  output  1  read request, held until mem_ready
mem_data  input  16  read data, valid when mem_ready=1
mem_ready  input  1  read complete this cycle (combinational ack)
ir  output  32  instruction to execution unit, stable from DISPATCH until WAIT_DONE exits
sel_eu  output  2  execution-unit operation class
cs  output  1  one-cycle dispatch strobe to execution unit
ready1  input  1  execution-unit ready (1=idle/done, 0=busy)
pc  output  AW-1  index of the current instruction
halted  output  1  HALT state reached
err  output  1  dispatch acknowledge timeout occurred

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, pc=RESET_PC.
  - ir, sel_eu, mem_addr, mem_rd, cs, halted, err all 0.
  - Any in-flight fetch or dispatch is abandoned.
- Instruction format:
  - Word address 2*pc holds ir[31:16]; 2*pc+1 holds ir[15:0].
  - Class field is ir[31:30]:
    - 00 = ALU immediate: sel_eu=00.
    - 01 = ALU register: sel_eu=01.
    - 10 = JMP: pc<=ir[AW-2:0], not dispatched.
    - 11 = HALT.
- States and transitions:
  - IDLE: start=1 -> FETCH_HI.
  - FETCH_HI: mem_addr={pc,1'b0}, mem_rd=1. On mem_ready=1, ir[31:16]<=mem_data -> FETCH_LO. Otherwise hold.
  - FETCH_LO: mem_addr={pc,1'b1}, mem_rd=1. On mem_ready=1, ir[15:0]<=mem_data -> DECODE.
  - DECODE:
    - Class 00/01: sel_eu set -> DISPATCH.
    - Class 10: pc<=target -> FETCH_HI.
    - Class 11: -> HALT.
  - DISPATCH: cs=1 for exactly this cycle; timeout counter cleared -> WAIT_BUSY.
  - WAIT_BUSY:
    - ready1=0 -> WAIT_DONE.
    - Counter increments each cycle ready1=1. When it reaches ACK_TIMEOUT, err<=1 -> HALT.
  - WAIT_DONE: ready1=1 -> pc<=pc+1 -> FETCH_HI.
  - HALT: halted=1, mem_rd=0. start=1 -> pc<=RESET_PC, halted<=0, err<=0 -> FETCH_HI.
- mem_rd is 0 in IDLE, DECODE, DISPATCH, WAIT_* and HALT.
- ir and sel_eu change only in FETCH_HI/FETCH_LO/DECODE; they are never modified while the execution unit is busy.
- pc increments modulo 2^(AW-1): pc=all-ones wraps to 0 with no flag.
- Latency with mem_ready tied to 1:
  - start sampled -> FETCH_HI at cycle 1, FETCH_LO at 2, DECODE at 3, cs high at cycle 4.
  - Next FETCH_HI begins 1 cycle after ready1 returns high.
- start is ignored outside IDLE/HALT.
- mem_ready outside a fetch state is ignored.
- ready1 that is still 1 on the cycle immediately after cs does not count as done; a 0 must be seen first.

Test Plan:
- Reset, then ALU immediate with mem_ready=1: memory word 0=0x0008, word 1=0x0005, start pulse.
  - -> ir=0x00080005, sel_eu=00, single cs pulse at cycle 4.
  - Model ready1 low 6 cycles; next mem_addr=2 appears 1 cycle after ready1 rises; pc=1.
- ALU register instruction 0x4001C000 at pc=1.
  - -> sel_eu=01, cs once, ir stable throughout WAIT_BUSY/WAIT_DONE.
- JMP at pc=2: words 0x8000, 0x0005.
  - -> no cs, next fetch mem_addr=10 (pc=5).
- HALT 0xC0000000.
  - -> halted=1, mem_rd=0.
  - start -> halted=0, next mem_addr=0.
- mem_ready stalled 3 cycles in each of FETCH_HI and FETCH_LO.
  - -> mem_rd and mem_addr held; ir assembled correctly; cs delayed by 6 cycles.
- ready1 held 1 after dispatch.
  - -> err=1 and halted=1 after 4 cycles in WAIT_BUSY.
- rst_n low mid-WAIT_DONE.
  - -> all outputs 0, pc=RESET_PC immediately; no fetch until start.
